// File: rtl/argmax_sequencer.sv
// Sequential argmax over a frame of NUM_VALUES streamed class scores.
// One shared comparator tracks the running maximum; the result is held on a valid/ready port.
module argmax_sequencer #(
  parameter int VALUE_WIDTH = 32,
  parameter int NUM_VALUES  = 10,
  parameter int SIGNED_CMP  = 0,
  localparam int IDX_W      = $clog2(NUM_VALUES)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   clear,
  input  logic                   in_valid,
  input  logic [VALUE_WIDTH-1:0] in_data,
  output logic                   in_ready,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [IDX_W-1:0]       max_index,
  output logic [VALUE_WIDTH-1:0] max_value,
  output logic                   busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DONE    = 2'd2
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VALUES - 1);

  state_t           state, state_next;
  logic [IDX_W-1:0] cnt;
  logic             accept;
  logic             last;
  logic             greater;

  // Handshake outputs decode from state only, so they never depend on inputs combinationally.
  assign in_ready  = (state == COLLECT);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

  assign accept = in_valid & in_ready & ~clear;
  assign last   = (cnt == LAST_IDX);

  always_comb begin
    if (SIGNED_CMP != 0) greater = $signed(in_data) > $signed(max_value);
    else                 greater = in_data > max_value;
  end

  // NOTE: every signal written here gets a default first, otherwise an incomplete path infers a latch.
  always_comb begin
    state_next = state;
    if (clear) begin
      state_next = IDLE;
    end else begin
      unique case (state)
        IDLE:    if (start)          state_next = COLLECT;
        COLLECT: if (accept && last) state_next = DONE;
        DONE:    if (out_ready)      state_next = IDLE;
        default:                     state_next = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Counter returns to zero after the last accept so it never exceeds NUM_VALUES-1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear || (state == IDLE && start)) begin
      cnt <= '0;
    end else if (accept) begin
      cnt <= last ? '0 : cnt + 1'b1;
    end
  end

  // NOTE: clear deliberately leaves the result registers alone; only rst_n zeroes them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      max_value <= '0;
      max_index <= '0;
    end else if (accept && (cnt == '0 || greater)) begin
      max_value <= in_data;
      max_index <= cnt;
    end
  end

endmodule
